// File: rtl/fetch_align.sv
// rtl/fetch_align.sv - halfword fetch queue that aligns 64-bit memory words to the instruction pc
// Optional feature: define FETCH_ALIGN_PERF_EN to add the stall_cycles counter output.
module fetch_align #(
  parameter logic [63:0] RESET_VECTOR = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_data,
  output logic [63:0] instOut,
  output logic        inst_valid,
  output logic [63:0] pc,
  input  logic        advance16,
  input  logic        advance32,
  input  logic        advance64,
  input  logic        redirect,
  input  logic [63:0] redirect_pc
`ifdef FETCH_ALIGN_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  logic [15:0] q_q [8];
  logic [15:0] q_d [8];
  logic [3:0]  count_q, count_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] fetch_addr_q, fetch_addr_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [1:0]  skip_q, skip_d;
  logic        mem_req_q, mem_req_d;
  logic        drop_q, drop_d;

  logic [3:0]  head_len;
  logic [15:0] win [4];
  logic [3:0]  adv_n;
  logic [3:0]  shift_n;
  logic        adv_ok;
  logic        ack_ok;

  // Head instruction length and the zero-filled four-halfword output window.
  always_comb begin
    head_len = 4'd1;
    if (q_q[0][15]) begin
      head_len = q_q[0][14] ? 4'd4 : 4'd2;
    end
    inst_valid = (count_q != 4'd0) && (count_q >= head_len);
    for (int i = 0; i < 4; i++) begin
      win[i] = (4'(i) < count_q) ? q_q[i] : 16'h0;
    end
  end

  assign instOut  = {win[0], win[1], win[2], win[3]};
  assign pc       = pc_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  // Next-state: redirect wins; otherwise shift out the consumed halfwords, then append an ack.
  always_comb begin
    logic [3:0] src;
    logic [3:0] pos;
    src = 4'd0;
    pos = 4'd0;

    adv_n = 4'd0;
    if (advance64) begin
      adv_n = 4'd4;
    end else if (advance32) begin
      adv_n = 4'd2;
    end else if (advance16) begin
      adv_n = 4'd1;
    end
    adv_ok  = inst_valid && (adv_n != 4'd0) && (adv_n <= count_q);
    shift_n = adv_ok ? adv_n : 4'd0;
    ack_ok  = mem_req_q && mem_ack;

    for (int i = 0; i < 8; i++) begin
      src    = 4'(i) + shift_n;
      q_d[i] = (src < 4'd8) ? q_q[src[2:0]] : 16'h0;
    end
    count_d      = count_q - shift_n;
    pc_d         = pc_q + {59'd0, shift_n, 1'b0};
    fetch_addr_d = fetch_addr_q;
    mem_addr_d   = mem_addr_q;
    skip_d       = skip_q;
    mem_req_d    = mem_req_q;
    drop_d       = drop_q;

    if (redirect) begin
      count_d      = 4'd0;
      pc_d         = redirect_pc & ~64'h1;
      fetch_addr_d = redirect_pc & ~64'h7;
      skip_d       = redirect_pc[2:1];
      if (mem_req_q && !mem_ack) begin
        // The in-flight word belongs to the old stream; keep the bus stable and discard it later.
        drop_d = 1'b1;
      end else begin
        mem_req_d  = 1'b1;
        mem_addr_d = redirect_pc & ~64'h7;
        drop_d     = 1'b0;
      end
    end else if (ack_ok && drop_q) begin
      // Stale word retired; re-request immediately at the redirected address.
      drop_d     = 1'b0;
      mem_addr_d = fetch_addr_q;
    end else if (ack_ok) begin
      for (int j = 0; j < 4; j++) begin
        if (4'(j) >= {2'b00, skip_q}) begin
          pos = count_d + 4'(j) - {2'b00, skip_q};
          if (pos < 4'd8) begin
            q_d[pos[2:0]] = mem_data[63-16*j -: 16];
          end
        end
      end
      count_d = count_d + 4'd4 - {2'b00, skip_q};
      if (count_d > 4'd8) begin
        count_d = 4'd8;
      end
      fetch_addr_d = fetch_addr_q + 64'd8;
      skip_d       = 2'd0;
      mem_req_d    = 1'b0;
    end else if (!mem_req_q && (count_d <= 4'd4)) begin
      mem_req_d  = 1'b1;
      mem_addr_d = fetch_addr_q;
    end
  end

  // State registers with asynchronous reset to the reset vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        q_q[i] <= 16'h0;
      end
      count_q      <= 4'd0;
      pc_q         <= RESET_VECTOR & ~64'h1;
      fetch_addr_q <= RESET_VECTOR & ~64'h7;
      mem_addr_q   <= RESET_VECTOR & ~64'h7;
      skip_q       <= RESET_VECTOR[2:1];
      mem_req_q    <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        q_q[i] <= q_d[i];
      end
      count_q      <= count_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      mem_addr_q   <= mem_addr_d;
      skip_q       <= skip_d;
      mem_req_q    <= mem_req_d;
      drop_q       <= drop_d;
    end
  end

`ifdef FETCH_ALIGN_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles without a complete instruction; a redirect restarts it.
  always_comb begin
    stall_d = stall_q;
    if (redirect) begin
      stall_d = 32'd0;
    end else if (!inst_valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_align.sv
// tb/tb_fetch_align.sv - self-checking bench for fetch_align: directed table, corner sequences, random vs model
module tb_fetch_align;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_data = 64'h0;
  logic [63:0] instOut;
  logic        inst_valid;
  logic [63:0] pc;
  logic        advance16 = 1'b0;
  logic        advance32 = 1'b0;
  logic        advance64 = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
`ifdef FETCH_ALIGN_PERF_EN
  logic [31:0] stall_cycles;
`endif

  fetch_align #(.RESET_VECTOR(64'h100)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .instOut(instOut),
    .inst_valid(inst_valid), .pc(pc), .advance16(advance16),
    .advance32(advance32), .advance64(advance64), .redirect(redirect),
    .redirect_pc(redirect_pc)
`ifdef FETCH_ALIGN_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    advance16 = 1'b0; advance32 = 1'b0; advance64 = 1'b0;
    mem_ack = 1'b0; mem_data = 64'h0; redirect = 1'b0; redirect_pc = 64'h0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        a16, a32, a64, ack;
    logic [63:0] data;
    logic [63:0] pc;
    logic [63:0] inst;
    logic        valid;
    logic        req;
    logic [63:0] addr;
  } vec_t;

  vec_t tbl[14];

  // Reference model: the halfword stream as a plain queue.
  logic [15:0] mq[$];
  logic [63:0] m_pc, m_fa, m_addr;
  int          m_skip;
  logic        m_req, m_drop;

  function automatic logic m_valid();
    int len;
    if (mq.size() == 0) return 1'b0;
    len = mq[0][15] ? (mq[0][14] ? 4 : 2) : 1;
    return mq.size() >= len;
  endfunction

  function automatic logic [63:0] m_window();
    logic [63:0] w;
    w = 64'h0;
    for (int i = 0; i < 4; i++) begin
      if (i < mq.size()) w[63-16*i -: 16] = mq[i];
    end
    return w;
  endfunction

  task automatic model_step();
    int n;
    if (redirect) begin
      if (m_req && !mem_ack) begin
        m_drop = 1'b1;
      end else begin
        m_req = 1'b1; m_drop = 1'b0; m_addr = redirect_pc & ~64'h7;
      end
      mq.delete();
      m_pc   = redirect_pc & ~64'h1;
      m_fa   = redirect_pc & ~64'h7;
      m_skip = int'(redirect_pc[2:1]);
    end else begin
      n = advance64 ? 4 : (advance32 ? 2 : (advance16 ? 1 : 0));
      if (m_valid() && n > 0 && n <= mq.size()) begin
        repeat (n) void'(mq.pop_front());
        m_pc = m_pc + 64'(2 * n);
      end
      if (m_req && mem_ack) begin
        if (m_drop) begin
          m_drop = 1'b0; m_addr = m_fa;
        end else begin
          for (int j = m_skip; j < 4; j++) mq.push_back(mem_data[63-16*j -: 16]);
          m_fa = m_fa + 64'd8; m_skip = 0; m_req = 1'b0;
        end
      end else if (!m_req && mq.size() <= 4) begin
        m_req = 1'b1; m_addr = m_fa;
      end
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0, 64'h0,                   64'h100, 64'h0,                   1'b0,1'b1,64'h100};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b1, 64'h0001_8002_0003_0004, 64'h100, 64'h0001_8002_0003_0004, 1'b1,1'b0,64'h100};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0, 64'h0,                   64'h102, 64'h8002_0003_0004_0000, 1'b1,1'b1,64'h108};
    tbl[3]  = '{1'b1,1'b1,1'b0,1'b0, 64'h0,                   64'h106, 64'h0004_0000_0000_0000, 1'b1,1'b1,64'h108};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b1, 64'h1005_1006_1007_1008, 64'h106, 64'h0004_1005_1006_1007, 1'b1,1'b0,64'h108};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b0, 64'h0,                   64'h108, 64'h1005_1006_1007_1008, 1'b1,1'b1,64'h110};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b1, 64'h2009_200A_200B_200C, 64'h10A, 64'h1006_1007_1008_2009, 1'b1,1'b0,64'h110};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b0, 64'h0,                   64'h112, 64'h200A_200B_200C_0000, 1'b1,1'b1,64'h118};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b1, 64'h0001_0002_C000_0005, 64'h112, 64'h200A_200B_200C_0001, 1'b1,1'b0,64'h118};
    tbl[9]  = '{1'b1,1'b0,1'b1,1'b0, 64'h0,                   64'h11A, 64'h0002_C000_0005_0000, 1'b1,1'b1,64'h120};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b0, 64'h0,                   64'h11C, 64'hC000_0005_0000_0000, 1'b0,1'b1,64'h120};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b0, 64'h0,                   64'h11C, 64'hC000_0005_0000_0000, 1'b0,1'b1,64'h120};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b1, 64'h0006_0007_0008_0009, 64'h11C, 64'hC000_0005_0006_0007, 1'b1,1'b0,64'h120};
    tbl[13] = '{1'b0,1'b0,1'b1,1'b0, 64'h0,                   64'h124, 64'h0008_0009_0000_0000, 1'b1,1'b1,64'h128};

    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 64'h100);
    chk("rst_req", {63'd0, mem_req}, 64'd0);
    chk("rst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_inst", instOut, 64'h0);
    chk("rst_addr", mem_addr, 64'h100);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      advance16 = tbl[i].a16; advance32 = tbl[i].a32; advance64 = tbl[i].a64;
      mem_ack = tbl[i].ack; mem_data = tbl[i].data;
      cyc();
      idle();
      chk($sformatf("row%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("row%0d_inst", i), instOut, tbl[i].inst);
      chk($sformatf("row%0d_valid", i), {63'd0, inst_valid}, {63'd0, tbl[i].valid});
      chk($sformatf("row%0d_req", i), {63'd0, mem_req}, {63'd0, tbl[i].req});
      chk($sformatf("row%0d_addr", i), mem_addr, tbl[i].addr);
    end

    // Redirect while the request to 0x128 is outstanding.
    redirect = 1'b1; redirect_pc = 64'h2006;
    cyc(); idle();
    chk("redir_pc", pc, 64'h2006);
    chk("redir_inst", instOut, 64'h0);
    chk("redir_req", {63'd0, mem_req}, 64'd1);
    chk("redir_addr_held", mem_addr, 64'h128);
    mem_ack = 1'b1; mem_data = 64'hDEAD_BEEF_DEAD_BEEF;
    cyc(); idle();
    chk("drop_req", {63'd0, mem_req}, 64'd1);
    chk("drop_addr", mem_addr, 64'h2000);
    chk("drop_inst", instOut, 64'h0);
    chk("drop_valid", {63'd0, inst_valid}, 64'd0);
    mem_ack = 1'b1; mem_data = 64'h1111_2222_3333_0044;
    cyc(); idle();
    chk("skip_inst", instOut, 64'h0044_0000_0000_0000);
    chk("skip_pc", pc, 64'h2006);
    chk("skip_valid", {63'd0, inst_valid}, 64'd1);
    chk("skip_req", {63'd0, mem_req}, 64'd0);

    // Redirect with no request outstanding.
    redirect = 1'b1; redirect_pc = 64'h3000;
    cyc(); idle();
    chk("redir2_req", {63'd0, mem_req}, 64'd1);
    chk("redir2_addr", mem_addr, 64'h3000);
    chk("redir2_pc", pc, 64'h3000);
    mem_ack = 1'b1; mem_data = 64'h4444_5555_6666_7777;
    cyc(); idle();
    chk("redir2_inst", instOut, 64'h4444_5555_6666_7777);
    cyc();
    chk("refetch_addr", mem_addr, 64'h3008);

    // Reset in the middle of a request, then a late ack that must be ignored.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", {63'd0, mem_req}, 64'd0);
    chk("async_rst_pc", pc, 64'h100);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_data = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc(); idle();
    chk("late_ack_req", {63'd0, mem_req}, 64'd1);
    chk("late_ack_addr", mem_addr, 64'h100);
    chk("late_ack_inst", instOut, 64'h0);
    chk("late_ack_valid", {63'd0, inst_valid}, 64'd0);

    // Randomized run against the queue model, starting from the state just checked.
    mq.delete();
    m_pc = 64'h100; m_fa = 64'h100; m_addr = 64'h100; m_skip = 0;
    m_req = 1'b1; m_drop = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      advance16 = ($urandom_range(2) == 0);
      advance32 = ($urandom_range(4) == 0);
      advance64 = ($urandom_range(6) == 0);
      mem_ack   = m_req ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      mem_data  = {$urandom, $urandom};
      redirect  = ($urandom_range(39) == 0);
      redirect_pc = ($urandom_range(3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15)))
                                             : {$urandom, $urandom};
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rnd%0d_pc", c), pc, m_pc);
      chk($sformatf("rnd%0d_valid", c), {63'd0, inst_valid}, {63'd0, m_valid()});
      chk($sformatf("rnd%0d_inst", c), instOut, m_window());
      chk($sformatf("rnd%0d_req", c), {63'd0, mem_req}, {63'd0, m_req});
      if (m_req) chk($sformatf("rnd%0d_addr", c), mem_addr, m_addr);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_align.md
FETCH_ALIGN -- requirements
Module: fetch_align

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 64'h0, meaning PC after reset (bit 0 ignored).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port mem_req  output  1  fetch request, held until mem_ack.
REQ-005 SHALL have port mem_addr  output  64  8-byte-aligned fetch address, stable while mem_req=1.
REQ-006 SHALL have port mem_ack  input  1  mem_data valid this cycle; completes the request.
REQ-007 SHALL have port mem_data  input  64  fetched word; halfword at lowest address in [63:48].
REQ-008 SHALL have port instOut  output  64  aligned window; halfword at pc in [63:48], next three halfwords below.
REQ-009 SHALL have port inst_valid  output  1  window holds one complete instruction.
REQ-010 SHALL have port pc  output  64  address of the instruction in instOut[63:48].
REQ-011 SHALL have ports advance16, advance32, advance64  input  1 each  consume 2/4/8 bytes.
REQ-012 SHALL have ports redirect  input  1, redirect_pc  input  64  flush and restart at redirect_pc.

Function
REQ-013 SHALL hold an 8-halfword queue with count 0..8; instOut = first four queued halfwords, unfilled positions 0.
REQ-014 Instruction length from head halfword: bit15=0 -> 1 halfword; bits[15:14]=10 -> 2; 11 -> 4.
REQ-015 inst_valid SHALL be 1 iff count>=1 and count>=length of head instruction; combinational from registered state.
REQ-016 Advance SHALL act only when inst_valid=1; otherwise ignored. Priority advance64>advance32>advance16 if several are asserted.
REQ-017 On accepted advance of n halfwords (n<=count): queue shifts by n, count-=n, pc+=2n, next cycle. If n>count: ignored.
REQ-018 mem_req SHALL rise (registered) when no request is outstanding and count<=4 (after this cycle's advance); mem_addr=fetch_addr; one request outstanding max.
REQ-019 On mem_ack (not dropped): the 4 halfwords, minus skip leading halfwords, append after the post-advance queue tail; fetch_addr+=8; skip cleared; mem_req drops same edge.
REQ-020 Same-cycle advance and mem_ack SHALL both apply: shift first, then append; count never exceeds 8.
REQ-021 redirect SHALL have highest priority: count=0, pc=redirect_pc with bit0 cleared, fetch_addr=redirect_pc&~7, skip=redirect_pc[2:1]; advance and mem_ack that cycle discarded.
REQ-022 Redirect while a request is outstanding SHALL set drop; that request's ack is discarded and clears drop; mem_req SHALL remain asserted with mem_addr changing to the new fetch_addr only after that ack.
REQ-023 Redirect with no outstanding request: new request issued next cycle at new fetch_addr.
REQ-024 fetch_addr and pc SHALL wrap modulo 2^64.

Reset
REQ-025 While rst=1: count=0, mem_req=0, drop=0, pc=RESET_VECTOR&~1, fetch_addr=RESET_VECTOR&~7, skip=RESET_VECTOR[2:1], inst_valid=0, instOut=0.
REQ-026 First cycle after rst deasserts SHALL assert mem_req with mem_addr=RESET_VECTOR&~7.
REQ-027 rst mid-request SHALL abandon it; a late mem_ack after reset SHALL be ignored unless mem_req=1.

Configuration
REQ-028 Macro FETCH_ALIGN_PERF_EN: when defined, adds output stall_cycles (32) counting cycles with inst_valid=0, saturating at 32'hFFFFFFFF, reset to 0, cleared on redirect; when undefined the port and counter are absent and all other behaviour is identical.

Verification
REQ-029 Reset, RESET_VECTOR=0x100, ack 0x0001_8002_0003_0004 -> mem_addr=0x100, then instOut=that word, inst_valid=1, pc=0x100.
REQ-030 Window 0x0001_8002_0003_0004: advance16 -> pc=0x102, instOut[63:32]=0x8002_0003; advance32 -> pc=0x106, instOut[63:48]=0x0004.
REQ-031 Head 0xC000 with count=2 -> inst_valid=0, advance64 ignored, pc unchanged; next ack fills -> inst_valid=1.
REQ-032 redirect_pc=0x2006 -> mem_addr=0x2000, first ack 0x1111_2222_3333_0044 -> instOut[63:48]=0x0044, pc=0x2006, count=1.
REQ-033 redirect while request to 0x108 outstanding -> its ack dropped, then mem_req with mem_addr=new target; no stale halfwords in instOut.
REQ-034 count=4 with simultaneous advance16 and mem_ack -> count=7, pc+=2, order preserved.
